// File: rtl/e203_nice_csr_bridge_pkg.sv
// rtl/e203_nice_csr_bridge_pkg.sv - shared constants, state encoding and window helper for the NICE CSR bridge
package e203_nice_csr_bridge_pkg;

   // Default extended-CSR window forwarded downstream (inclusive bounds)
   localparam logic [11:0] E203_NICE_CSR_ADDR_LO = 12'hBC0;
   localparam logic [11:0] E203_NICE_CSR_ADDR_HI = 12'hBFF;

   // Bridge FSM encoding
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_RSP  = 2'd2
   } state_e;

   // True when addr lies inside [lo, hi]
   function automatic logic addr_in_window(input logic [11:0] addr,
                                           input logic [11:0] lo,
                                           input logic [11:0] hi);
      return (addr >= lo) && (addr <= hi);
   endfunction

endpackage

// File: rtl/e203_nice_csr_tmo_cnt.sv
// rtl/e203_nice_csr_tmo_cnt.sv - downstream-ready wait counter, used only when E203_NICE_CSR_TMO_EN is defined
module e203_nice_csr_tmo_cnt #(
   parameter int unsigned TMO_CYCLES = 255
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int unsigned CW = $clog2(TMO_CYCLES + 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   // Count stalled cycles; held at zero while clear is asserted
   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (enable) begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   // Counter register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // The stalled cycle that brings the count to TMO_CYCLES is the last one allowed
   assign expired = enable && (cnt_q == CW'(TMO_CYCLES - 1));

endmodule

// File: rtl/e203_nice_csr_bridge.sv
// rtl/e203_nice_csr_bridge.sv - CSR request bridge onto the NICE extended-CSR handshake; timeout under E203_NICE_CSR_TMO_EN
module e203_nice_csr_bridge
   import e203_nice_csr_bridge_pkg::*;
#(
   parameter logic [11:0] ADDR_LO    = E203_NICE_CSR_ADDR_LO,
   parameter logic [11:0] ADDR_HI    = E203_NICE_CSR_ADDR_HI,
   parameter int unsigned TMO_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        csr_req_valid,
   output logic        csr_req_ready,
   input  logic [11:0] csr_req_addr,
   input  logic        csr_req_wr,
   input  logic [31:0] csr_req_wdata,
   output logic        csr_rsp_valid,
   input  logic        csr_rsp_ready,
   output logic [31:0] csr_rsp_rdata,
   output logic        csr_rsp_err,
   output logic        nice_csr_valid,
   input  logic        nice_csr_ready,
   output logic [31:0] nice_csr_addr,
   output logic        nice_csr_wr,
   output logic [31:0] nice_csr_wdata,
   input  logic [31:0] nice_csr_rdata
);

   state_e      state_q, state_d;
   logic [11:0] addr_q, addr_d;
   logic        wr_q, wr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] rdata_q, rdata_d;
   logic        err_q, err_d;
   logic        tmo_expired;

`ifdef E203_NICE_CSR_TMO_EN
   e203_nice_csr_tmo_cnt #(
      .TMO_CYCLES (TMO_CYCLES)
   ) u_tmo_cnt (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (state_q != ST_REQ),
      .enable  ((state_q == ST_REQ) && !nice_csr_ready),
      .expired (tmo_expired)
   );
`else
   // No counter: REQ waits for ready forever (zero for any legal TMO_CYCLES)
   assign tmo_expired = (TMO_CYCLES == 0);
`endif

   // Next-state and captured request/response fields
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      wr_d    = wr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      case (state_q)
         ST_IDLE: begin
            if (csr_req_valid) begin
               addr_d  = csr_req_addr;
               wr_d    = csr_req_wr;
               wdata_d = csr_req_wdata;
               if (addr_in_window(csr_req_addr, ADDR_LO, ADDR_HI)) begin
                  state_d = ST_REQ;
               end else begin
                  rdata_d = '0;
                  err_d   = 1'b1;
                  state_d = ST_RSP;
               end
            end
         end
         ST_REQ: begin
            // Ready takes priority over a coinciding timeout
            if (nice_csr_ready) begin
               rdata_d = wr_q ? 32'h0 : nice_csr_rdata;
               err_d   = 1'b0;
               state_d = ST_RSP;
            end else if (tmo_expired) begin
               rdata_d = '0;
               err_d   = 1'b1;
               state_d = ST_RSP;
            end
         end
         ST_RSP: begin
            if (csr_rsp_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         addr_q  <= '0;
         wr_q    <= 1'b0;
         wdata_q <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         wr_q    <= wr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   assign csr_req_ready  = (state_q == ST_IDLE);
   assign nice_csr_valid = (state_q == ST_REQ);
   assign csr_rsp_valid  = (state_q == ST_RSP);
   assign csr_rsp_rdata  = rdata_q;
   assign csr_rsp_err    = err_q;
   assign nice_csr_addr  = {20'b0, addr_q};
   assign nice_csr_wr    = wr_q;
   assign nice_csr_wdata = wdata_q;

endmodule

// File: tb/tb_e203_nice_csr_bridge.sv
// tb/tb_e203_nice_csr_bridge.sv - self-checking bench for e203_nice_csr_bridge (timeout cases under E203_NICE_CSR_TMO_EN)
module tb_e203_nice_csr_bridge;

   localparam int TMO = 8;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        csr_req_valid = 1'b0;
   logic        csr_req_ready;
   logic [11:0] csr_req_addr = '0;
   logic        csr_req_wr = 1'b0;
   logic [31:0] csr_req_wdata = '0;
   logic        csr_rsp_valid;
   logic        csr_rsp_ready = 1'b0;
   logic [31:0] csr_rsp_rdata;
   logic        csr_rsp_err;
   logic        nice_csr_valid;
   logic        nice_csr_ready = 1'b0;
   logic [31:0] nice_csr_addr;
   logic        nice_csr_wr;
   logic [31:0] nice_csr_wdata;
   logic [31:0] nice_csr_rdata = '0;

   int n_assert = 0;
   int n_fail   = 0;

   e203_nice_csr_bridge #(
      .ADDR_LO    (12'hBC0),
      .ADDR_HI    (12'hBFF),
      .TMO_CYCLES (TMO)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .csr_req_valid  (csr_req_valid),
      .csr_req_ready  (csr_req_ready),
      .csr_req_addr   (csr_req_addr),
      .csr_req_wr     (csr_req_wr),
      .csr_req_wdata  (csr_req_wdata),
      .csr_rsp_valid  (csr_rsp_valid),
      .csr_rsp_ready  (csr_rsp_ready),
      .csr_rsp_rdata  (csr_rsp_rdata),
      .csr_rsp_err    (csr_rsp_err),
      .nice_csr_valid (nice_csr_valid),
      .nice_csr_ready (nice_csr_ready),
      .nice_csr_addr  (nice_csr_addr),
      .nice_csr_wr    (nice_csr_wr),
      .nice_csr_wdata (nice_csr_wdata),
      .nice_csr_rdata (nice_csr_rdata)
   );

   always #5 clk = ~clk;

`ifdef E203_NICE_CSR_TMO_EN
   localparam bit TMO_ON = 1'b1;
`else
   localparam bit TMO_ON = 1'b0;
`endif

   typedef struct {
      logic        err;
      logic [31:0] rdata;
      int          vcycles;
      int          latency;
   } exp_t;

   // Reference: expected outcome of one access given how long downstream stalls
   function automatic exp_t model(input logic [11:0] addr, input logic wr,
                                  input int stall, input logic [31:0] rd);
      exp_t e;
      if (addr < 12'hBC0 || addr > 12'hBFF) begin
         e.err = 1'b1; e.rdata = 32'h0; e.vcycles = 0; e.latency = 1;
      end else if (TMO_ON && stall >= TMO) begin
         e.err = 1'b1; e.rdata = 32'h0; e.vcycles = TMO; e.latency = TMO + 1;
      end else begin
         e.err = 1'b0; e.rdata = wr ? 32'h0 : rd; e.vcycles = stall + 1; e.latency = stall + 2;
      end
      return e;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One access: request, downstream responder with 'stall' low-ready cycles, response held 'hold' cycles
   task automatic do_txn(input logic [11:0] addr, input logic wr, input logic [31:0] wdata,
                         input int stall, input logic [31:0] rd, input int hold);
      exp_t e;
      int   lat;
      int   vcnt;
      e = model(addr, wr, stall, rd);
      chk("req_ready_idle", 32'(csr_req_ready), 32'h1);
      csr_req_valid = 1'b1;
      csr_req_addr  = addr;
      csr_req_wr    = wr;
      csr_req_wdata = wdata;
      @(negedge clk);
      csr_req_valid = 1'b0;
      csr_req_addr  = 12'($urandom);
      csr_req_wdata = $urandom;
      lat  = 1;
      vcnt = 0;
      while (!csr_rsp_valid && lat < 200) begin
         chk("req_ready_busy", 32'(csr_req_ready), 32'h0);
         if (nice_csr_valid) begin
            chk("nice_addr", nice_csr_addr, {20'h0, addr});
            chk("nice_wr", 32'(nice_csr_wr), 32'(wr));
            chk("nice_wdata", nice_csr_wdata, wdata);
            vcnt++;
            nice_csr_ready = (vcnt == stall + 1);
            nice_csr_rdata = nice_csr_ready ? rd : $urandom;
         end else begin
            nice_csr_ready = 1'b0;
         end
         @(negedge clk);
         lat++;
      end
      nice_csr_ready = 1'b0;
      chk("rsp_latency", 32'(lat), 32'(e.latency));
      chk("nice_valid_cycles", 32'(vcnt), 32'(e.vcycles));
      for (int h = 0; h <= hold; h++) begin
         chk("rsp_valid", 32'(csr_rsp_valid), 32'h1);
         chk("rsp_err", 32'(csr_rsp_err), 32'(e.err));
         chk("rsp_rdata", csr_rsp_rdata, e.rdata);
         chk("nice_valid_in_rsp", 32'(nice_csr_valid), 32'h0);
         chk("req_ready_in_rsp", 32'(csr_req_ready), 32'h0);
         csr_rsp_ready = (h == hold);
         @(negedge clk);
      end
      csr_rsp_ready = 1'b0;
      chk("rsp_valid_after", 32'(csr_rsp_valid), 32'h0);
   endtask

   initial begin
      exp_t dummy;
      logic [11:0] a;
      // Reset state
      #12;
      chk("rst_req_ready", 32'(csr_req_ready), 32'h1);
      chk("rst_rsp_valid", 32'(csr_rsp_valid), 32'h0);
      chk("rst_rsp_rdata", csr_rsp_rdata, 32'h0);
      chk("rst_rsp_err", 32'(csr_rsp_err), 32'h0);
      chk("rst_nice_valid", 32'(nice_csr_valid), 32'h0);
      chk("rst_nice_addr", nice_csr_addr, 32'h0);
      chk("rst_nice_wr", 32'(nice_csr_wr), 32'h0);
      chk("rst_nice_wdata", nice_csr_wdata, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Directed: read with ready tied high, delayed write, out-of-range, slow consumer
      do_txn(12'hBC5, 1'b0, 32'h0, 0, 32'hDEAD_BEEF, 0);
      do_txn(12'hBFF, 1'b1, 32'h1234_5678, 5, 32'hFFFF_FFFF, 0);
      do_txn(12'h300, 1'b0, 32'h0, 0, 32'h5555_AAAA, 0);
      do_txn(12'hBC0, 1'b0, 32'h0, 1, 32'hA5A5_0001, 4);
      do_txn(12'hBBF, 1'b1, 32'h0BAD_F00D, 0, 32'h1, 0);
      do_txn(12'hC00, 1'b0, 32'h0, 0, 32'h2, 0);
`ifdef E203_NICE_CSR_TMO_EN
      do_txn(12'hBD0, 1'b0, 32'h0, 1000, 32'h3, 0);
      do_txn(12'hBD1, 1'b0, 32'h0, TMO - 1, 32'hCAFE_0007, 0);
`endif

      // Randomized accesses, back-to-back
      for (int i = 0; i < 24; i++) begin
         case ($urandom_range(0, 3))
            0: a = 12'hBC0 + 12'($urandom_range(0, 63));
            1: a = ($urandom_range(0, 1) == 0) ? 12'hBC0 : 12'hBFF;
            2: a = ($urandom_range(0, 1) == 0) ? 12'hBBF : 12'hC00;
            default: a = 12'($urandom);
         endcase
         do_txn(a, 1'($urandom), $urandom, $urandom_range(0, 10), $urandom, $urandom_range(0, 3));
      end

      // Asynchronous reset while a downstream request is pending
      csr_req_valid = 1'b1;
      csr_req_addr  = 12'hBE0;
      csr_req_wr    = 1'b1;
      csr_req_wdata = 32'h7777_0000;
      @(negedge clk);
      csr_req_valid = 1'b0;
      chk("pre_rst_nice_valid", 32'(nice_csr_valid), 32'h1);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_nice_valid", 32'(nice_csr_valid), 32'h0);
      chk("mid_rst_rsp_valid", 32'(csr_rsp_valid), 32'h0);
      chk("mid_rst_req_ready", 32'(csr_req_ready), 32'h1);
      chk("mid_rst_nice_addr", nice_csr_addr, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_req_ready", 32'(csr_req_ready), 32'h1);
      chk("post_rst_nice_valid", 32'(nice_csr_valid), 32'h0);
      dummy = model(12'hBC1, 1'b0, 0, 32'h0123_4567);
      do_txn(12'hBC1, 1'b0, 32'h0, 0, 32'h0123_4567, 0);
      chk("post_rst_model_err", 32'(dummy.err), 32'(csr_rsp_err));

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
